// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter and destination-register scoreboard for the RV32I
//   register file write port. The ALU and LSU writeback sources share one
//   write port through a round-robin valid/ready handshake. A one-entry
//   output stage drives the register file and doubles as a forwarding source.
//   A busy mask tracks issued-but-not-yet-written destination registers.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   alu_valid/ready      ALU writeback handshake, with alu_rd / alu_data
//   lsu_valid/ready      LSU writeback handshake, with lsu_rd / lsu_data
//   iss_set, iss_rd      destination register issued this cycle
//   flush                pipeline flush (clears busy, not the output stage)
//   rf_wen/addr/data     register file write port, also the forwarding value
//   busy                 pending-write mask, bit 0 always 0
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_set,
  input  logic [4:0]      iss_rd,
  input  logic            flush,
  output logic            rf_wen,
  output logic [4:0]      rf_addr,
  output logic [XLEN-1:0] rf_data,
  output logic [NREG-1:0] busy
);

  // prio: 0 = ALU wins a tie, 1 = LSU wins a tie
  logic            prio;
  logic            grantAlu;
  logic            grantLsu;
  logic            accept;
  logic [4:0]      selRd;
  logic [XLEN-1:0] selData;
  logic [NREG-1:0] busyQ;
  logic [NREG-1:0] busyNext;
  logic [NREG-1:0] issMask;
  logic [NREG-1:0] retireMask;

  // Grant is never gated by the output stage: the write port drains every cycle.
  always_comb begin
    grantAlu = 1'b0;
    grantLsu = 1'b0;
    if (rst_n) begin
      if (alu_valid && lsu_valid) begin
        grantAlu = ~prio;
        grantLsu = prio;
      end else begin
        grantAlu = alu_valid;
        grantLsu = lsu_valid;
      end
    end
  end

  assign alu_ready = grantAlu;
  assign lsu_ready = grantLsu;
  assign accept    = grantAlu | grantLsu;

  always_comb begin
    selRd   = alu_rd;
    selData = alu_data;
    if (grantLsu) begin
      selRd   = lsu_rd;
      selData = lsu_data;
    end
  end

  // After a grant the other source gets priority; idle cycles keep prio.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= 1'b1;
    end else if (grantAlu) begin
      prio <= 1'b1;
    end else if (grantLsu) begin
      prio <= 1'b0;
    end
  end

  // Output stage; x0 writes are accepted but never raise rf_wen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (accept) begin
      rf_wen  <= (selRd != 5'd0);
      rf_addr <= selRd;
      rf_data <= selData;
    end else begin
      rf_wen  <= 1'b0;
    end
  end

  // Scoreboard: a same-cycle issue beats a retire of the same register,
  // since the retiring write belongs to an older instruction.
  always_comb begin
    issMask    = '0;
    retireMask = '0;
    if (iss_set) begin
      issMask[iss_rd] = 1'b1;
    end
    if (rf_wen) begin
      retireMask[rf_addr] = 1'b1;
    end
    if (flush) begin
      busyNext = '0;
    end else begin
      busyNext = (busyQ & ~retireMask) | issMask;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyNext;
    end
  end

  assign busy = busyQ;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and register scoreboard for the RV32I register file write port. Two writeback sources share the single write port through a round-robin valid/ready handshake: the ALU path and the load/store unit. A one-entry output stage drives the write port and also serves as a forwarding source. A 32-bit busy mask tracks destination registers that are issued but not yet written, and the decode/hazard logic uses it to stall.

## Interface
Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; index width is 5.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  load data.
- iss_set  in  1  an instruction with a destination issued this cycle.
- iss_rd  in  5  its destination register.
- flush  in  1  pipeline flush.
- rf_wen  out  1  register file write enable (to RegWEn).
- rf_addr  out  5  write address (to AddrD).
- rf_data  out  XLEN  write data (to DataD).
- busy  out  NREG  pending-write mask; bit i set means register i has an outstanding write.

## Operation
- Handshake: a request is accepted when valid && ready. Ready is combinational from both valids and the priority bit.
  - rd and data must be held stable while valid is high and ready is low.
  - A source must not drop valid without acceptance.
- Arbitration uses a priority bit `prio` (0 = ALU, 1 = LSU); reset value is 1 (LSU).
  - Only one source valid: that source is granted and `prio` is set to the other source.
  - Both valid: the source named by `prio` is granted, then `prio` flips.
  - Neither valid: no grant, `prio` unchanged.
  - At most one ready is high per cycle. The grant is never gated by rf_wen, because the write port always drains.
- Output stage: on acceptance, {rd, data} are registered into rf_addr and rf_data.
  - rf_wen is registered as (rd != 0).
  - With no acceptance, rf_wen becomes 0 and rf_addr/rf_data hold their last values.
- x0: requests to rd = 0 are accepted normally, but never assert rf_wen and never touch busy.
- Scoreboard, next-state of each bit i in priority order:
  - rst_n low: 0.
  - flush: 0 for all bits; a same-cycle iss_set is ignored.
  - iss_set && iss_rd == i && i != 0: 1.
  - rf_wen && rf_addr == i: 0.
  - Otherwise: hold.
- Same-cycle iss_set and retire on the same register: set wins. The retire belongs to an older instruction.
- busy[0] is constant 0.
- flush does not cancel the output stage. A write already accepted still commits; only its busy bit is lost.
- Forwarding: while rf_wen is high, {rf_addr, rf_data} is the newest value of that register. Decode must compare against it, because the register file reads the old value until the edge that ends this cycle.

## Timing
- Reset values: rf_wen 0, rf_addr 0, rf_data 0, busy all 0, prio 1. While rst_n is low, alu_ready and lsu_ready are 0.
- Latency: a request accepted in cycle N shows rf_wen high in cycle N+1. The register file updates at the edge ending N+1, so the value is readable in N+2.
- Busy: iss_set in cycle N shows the busy bit in N+1. Retire with rf_wen high in cycle M clears the bit in M+1.
- Throughput: one write per cycle sustained. With both sources continuously valid, each source gets one grant every 2 cycles.
- Reset mid-operation: output-stage contents are discarded and rf_wen is 0 the cycle after reset is sampled. Pending requests are re-arbitrated with prio = 1.

## Test plan
- Reset: hold rst_n low 2 cycles with both valids high -> both readys 0. Release -> busy = 0 and rf_wen = 0, and the first cycle grants the LSU (lsu_ready = 1).
- Contention: both valid continuously, alu_rd = 5/alu_data = 0xAAAA0005 and lsu_rd = 6/lsu_data = 0x55550006 -> grants alternate ALU and LSU after the first LSU grant. rf_wen stays high every cycle with matching addr/data one cycle after each grant.
- Backpressure hold: ALU valid and stalled one cycle by an LSU grant -> alu_ready goes high the next cycle and exactly one write to the ALU's rd is produced, with no duplicate.
- x0: ALU request with rd = 0 and data 0xDEADBEEF -> alu_ready = 1, rf_wen stays 0 the next cycle, and busy is unchanged.
- Scoreboard race: iss_set with rd = 7; later iss_set rd = 7 in the same cycle rf_wen writes rd 7 -> busy[7] stays 1. A following retire of rd 7 clears it a cycle after rf_wen.
- Flush: busy = 0x0000_00F0 with a write to rd 4 accepted in the same cycle as flush and iss_set rd = 9 -> the next cycle busy = 0 with no bit 9, and rf_wen = 1 with rf_addr = 4.
